// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: RISC-V execute stage with forwarding, ALU/branch resolution,
// an optional iterative shift-add multiplier and the EX/MEM pipeline register.
module ex_stage_pipe #(
  parameter int XLEN = 32,
  parameter int REG_AW = 5,
  parameter int MUL_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write_e,
  input  logic              mem_write_e,
  input  logic              jump_e,
  input  logic              jalr_e,
  input  logic              branch_e,
  input  logic              alu_src_e,
  input  logic [1:0]        result_src_e,
  input  logic [2:0]        branch_op_e,
  input  logic [3:0]        alu_control_e,
  input  logic [XLEN-1:0]   rd1_e,
  input  logic [XLEN-1:0]   rd2_e,
  input  logic [XLEN-1:0]   pc_e,
  input  logic [XLEN-1:0]   imm_e,
  input  logic [XLEN-1:0]   pc_plus4_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [1:0]        fwd_a_e,
  input  logic [1:0]        fwd_b_e,
  input  logic [XLEN-1:0]   result_w,
  input  logic              stall_m_i,
  input  logic              flush_e_i,
  output logic              pc_src_e,
  output logic [XLEN-1:0]   pc_target_e,
  output logic              busy_e,
  output logic              reg_write_m,
  output logic              mem_write_m,
  output logic [1:0]        result_src_m,
  output logic [XLEN-1:0]   alu_result_m,
  output logic [XLEN-1:0]   write_data_m,
  output logic [XLEN-1:0]   pc_plus4_m,
  output logic [REG_AW-1:0] rd_m
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_out, jt, mul_a, mul_b, prod;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sh;
  logic mul_op, taken, eq, lt, ltu;
  always_comb begin
    src_a = fwd_a_e == 2'b01 ? result_w : fwd_a_e == 2'b10 ? alu_result_m : rd1_e;
    fwd_b = fwd_b_e == 2'b01 ? result_w : fwd_b_e == 2'b10 ? alu_result_m : rd2_e;
    src_b = alu_src_e ? imm_e : fwd_b;
    sh = src_b[SW-1:0];
    eq = src_a == src_b;
    lt = $signed(src_a) < $signed(src_b);
    ltu = src_a < src_b;
    jt = src_a + imm_e;
    mul_op = (MUL_EN != 0) && alu_control_e == 4'd11;
  end
  // MUL (code 11) yields 0 here; its product only reaches EX/MEM from the multiplier in DONE
  always_comb begin
    case (alu_control_e)
      4'd0:    alu_out = src_a + src_b;
      4'd1:    alu_out = src_a - src_b;
      4'd2:    alu_out = src_a & src_b;
      4'd3:    alu_out = src_a | src_b;
      4'd4:    alu_out = src_a ^ src_b;
      4'd5:    alu_out = {{(XLEN-1){1'b0}}, lt};
      4'd6:    alu_out = {{(XLEN-1){1'b0}}, ltu};
      4'd7:    alu_out = src_a << sh;
      4'd8:    alu_out = src_a >> sh;
      4'd9:    alu_out = $signed(src_a) >>> sh;
      4'd10:   alu_out = src_b;
      default: alu_out = '0;
    endcase
  end
  always_comb begin
    taken = branch_op_e == 3'b000 ? eq :
            branch_op_e == 3'b001 ? !eq :
            branch_op_e == 3'b100 ? lt :
            branch_op_e == 3'b101 ? !lt :
            branch_op_e == 3'b110 ? ltu :
            branch_op_e == 3'b111 ? !ltu : 1'b0;
    pc_src_e = (jump_e | (branch_e & taken)) & ~flush_e_i;
    pc_target_e = jalr_e ? {jt[XLEN-1:1], 1'b0} : pc_e + imm_e;
    busy_e = (state == IDLE && mul_op) || state == RUN;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = mul_op && !flush_e_i && !stall_m_i ? RUN : IDLE;
      RUN:     state_n = stall_m_i ? RUN : flush_e_i ? IDLE : cnt == CW'(1) ? DONE : RUN;
      DONE:    state_n = stall_m_i ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // One shift-add step per RUN cycle; after XLEN steps prod holds the low XLEN product bits
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      mul_a <= '0;
      mul_b <= '0;
      prod <= '0;
    end else if (state == IDLE && state_n == RUN) begin
      cnt <= CW'(XLEN);
      mul_a <= src_a;
      mul_b <= src_b;
      prod <= '0;
    end else if (state == RUN && state_n != IDLE && !stall_m_i) begin
      cnt <= cnt - CW'(1);
      prod <= prod + (mul_b[0] ? mul_a : '0);
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
    end else if (state_n == IDLE) begin
      cnt <= '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || (!stall_m_i && (flush_e_i || busy_e))) begin
      reg_write_m <= 1'b0;
      mem_write_m <= 1'b0;
      result_src_m <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m <= '0;
      rd_m <= '0;
    end else if (!stall_m_i) begin
      reg_write_m <= reg_write_e;
      mem_write_m <= mem_write_e;
      result_src_m <= result_src_e;
      alu_result_m <= state == DONE ? prod : alu_out;
      write_data_m <= fwd_b;
      pc_plus4_m <= pc_plus4_e;
      rd_m <= rd_e;
    end
  end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: directed and randomized checks of ex_stage_pipe against a behavioural model.
module tb_ex_stage_pipe;
  localparam int XLEN = 32;
  logic clk, rst;
  logic reg_write_e, mem_write_e, jump_e, jalr_e, branch_e, alu_src_e;
  logic [1:0] result_src_e, fwd_a_e, fwd_b_e;
  logic [2:0] branch_op_e;
  logic [3:0] alu_control_e;
  logic [31:0] rd1_e, rd2_e, pc_e, imm_e, pc_plus4_e, result_w;
  logic [4:0] rd_e;
  logic stall_m_i, flush_e_i;
  logic pc_src_e, busy_e, reg_write_m, mem_write_m;
  logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus4_m;
  logic [1:0] result_src_m;
  logic [4:0] rd_m;
  int checks = 0;
  int failures = 0;

  ex_stage_pipe #(.XLEN(32), .REG_AW(5), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .jump_e(jump_e), .jalr_e(jalr_e), .branch_e(branch_e), .alu_src_e(alu_src_e),
    .result_src_e(result_src_e), .branch_op_e(branch_op_e), .alu_control_e(alu_control_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .imm_e(imm_e), .pc_plus4_e(pc_plus4_e),
    .rd_e(rd_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .result_w(result_w),
    .stall_m_i(stall_m_i), .flush_e_i(flush_e_i), .pc_src_e(pc_src_e),
    .pc_target_e(pc_target_e), .busy_e(busy_e), .reg_write_m(reg_write_m),
    .mem_write_m(mem_write_m), .result_src_m(result_src_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m), .rd_m(rd_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    {reg_write_e, mem_write_e, jump_e, jalr_e, branch_e, alu_src_e} = '0;
    {result_src_e, fwd_a_e, fwd_b_e, branch_op_e, alu_control_e} = '0;
    {rd1_e, rd2_e, pc_e, imm_e, pc_plus4_e, result_w} = '0;
    rd_e = '0;
    stall_m_i = 1'b0;
    flush_e_i = 1'b0;
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (sa < sb) ? 32'd1 : 32'd0;
      6: return (a < b) ? 32'd1 : 32'd0;
      7: return a << b[4:0];
      8: return a >> b[4:0];
      9: return sa >>> b[4:0];
      10: return b;
      11: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (f)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return sa < sb;
      3'b101: return sa >= sb;
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    nop();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({reg_write_m, mem_write_m, result_src_m, rd_m} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {reg_write_m, mem_write_m, result_src_m, rd_m});
    end
    checks++;
    if ({alu_result_m, write_data_m, pc_plus4_m, busy_e, pc_src_e} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h busy=%b pcsrc=%b exp=0", alu_result_m, write_data_m, pc_plus4_m, busy_e, pc_src_e);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    nop();
    rd1_e = 32'hFFFF_FFFF; imm_e = 32'd1; alu_src_e = 1'b1; reg_write_e = 1'b1; rd_e = 5'd3;
    tick();
    checks++;
    if (alu_result_m !== 32'd0 || reg_write_m !== 1'b1 || rd_m !== 5'd3) begin
      failures++;
      $display("FAIL add_wrap got=%h rw=%b rd=%0d exp=0 rw=1 rd=3", alu_result_m, reg_write_m, rd_m);
    end
    rd1_e = 32'h8000_0000; imm_e = 32'd31; alu_control_e = 4'd9;
    tick();
    checks++;
    if (alu_result_m !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL sra31 got=%h exp=ffffffff", alu_result_m);
    end
    alu_control_e = 4'd10; imm_e = 32'd7;
    tick();
    checks++;
    if (alu_result_m !== 32'd7) begin
      failures++;
      $display("FAIL pass_b got=%h exp=7", alu_result_m);
    end
    alu_control_e = 4'd1; alu_src_e = 1'b0; fwd_a_e = 2'b01; fwd_b_e = 2'b10;
    result_w = 32'd5; rd1_e = 32'h1234; rd2_e = 32'h5678;
    tick();
    checks++;
    if (alu_result_m !== 32'hFFFF_FFFE || write_data_m !== 32'd7) begin
      failures++;
      $display("FAIL fwd_sub got=%h wd=%h exp=fffffffe wd=7", alu_result_m, write_data_m);
    end
    nop();
    branch_e = 1'b1; rd1_e = 32'hFFFF_FFFF; rd2_e = 32'd1; branch_op_e = 3'b100;
    pc_e = 32'h400; imm_e = 32'h20;
    #1;
    checks++;
    if (pc_src_e !== 1'b1 || pc_target_e !== 32'h420) begin
      failures++;
      $display("FAIL blt got=%b tgt=%h exp=1 tgt=420", pc_src_e, pc_target_e);
    end
    branch_op_e = 3'b110;
    #1;
    checks++;
    if (pc_src_e !== 1'b0) begin
      failures++;
      $display("FAIL bltu got=%b exp=0", pc_src_e);
    end
    nop();
    jump_e = 1'b1; jalr_e = 1'b1; rd1_e = 32'h1001; imm_e = 32'd2;
    #1;
    checks++;
    if (pc_src_e !== 1'b1 || pc_target_e !== 32'h1002) begin
      failures++;
      $display("FAIL jalr got=%b tgt=%h exp=1 tgt=1002", pc_src_e, pc_target_e);
    end
    flush_e_i = 1'b1;
    #1;
    checks++;
    if (pc_src_e !== 1'b0) begin
      failures++;
      $display("FAIL jump_flush got=%b exp=0", pc_src_e);
    end
    nop();
    tick();
  endtask

  task automatic test_random();
    logic [31:0] prev, a, bf, b, res;
    logic [104:0] got, exp;
    nop();
    tick();
    prev = 32'd0;
    for (int i = 0; i < 80; i++) begin
      int op;
      op = $urandom_range(0, 15);
      if (op == 11) op = 0;
      alu_control_e = op[3:0];
      rd1_e = $urandom; rd2_e = $urandom; imm_e = $urandom; result_w = $urandom;
      pc_e = $urandom; pc_plus4_e = $urandom;
      if (i % 4 == 0) rd2_e = rd1_e;
      alu_src_e = 1'($urandom); fwd_a_e = 2'($urandom); fwd_b_e = 2'($urandom);
      reg_write_e = 1'($urandom); mem_write_e = 1'($urandom); result_src_e = 2'($urandom);
      rd_e = 5'($urandom); branch_op_e = 3'($urandom); branch_e = 1'($urandom);
      jump_e = ($urandom_range(0, 3) == 0); jalr_e = 1'($urandom);
      a = fwd_a_e == 2'b01 ? result_w : fwd_a_e == 2'b10 ? prev : rd1_e;
      bf = fwd_b_e == 2'b01 ? result_w : fwd_b_e == 2'b10 ? prev : rd2_e;
      b = alu_src_e ? imm_e : bf;
      res = ref_alu(op, a, b);
      #1;
      checks++;
      if (pc_src_e !== (jump_e | (branch_e & ref_taken(branch_op_e, a, b))) ||
          pc_target_e !== (jalr_e ? ((a + imm_e) & 32'hFFFF_FFFE) : pc_e + imm_e)) begin
        failures++;
        $display("FAIL rand_branch[%0d] got=%b tgt=%h f3=%b a=%h b=%h", i, pc_src_e, pc_target_e, branch_op_e, a, b);
      end
      exp = {res, bf, pc_plus4_e, rd_e, reg_write_e, mem_write_e, result_src_e};
      tick();
      got = {alu_result_m, write_data_m, pc_plus4_m, rd_m, reg_write_m, mem_write_m, result_src_m};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL rand_alu[%0d] op=%0d got=%h exp=%h", i, op, got, exp);
      end
      prev = res;
    end
    nop();
    tick();
  endtask

  task automatic test_stall_flush();
    nop();
    alu_control_e = 4'd10; alu_src_e = 1'b1; imm_e = 32'h55; reg_write_e = 1'b1; rd_e = 5'd7;
    tick();
    checks++;
    if (alu_result_m !== 32'h55 || rd_m !== 5'd7) begin
      failures++;
      $display("FAIL capture got=%h rd=%0d exp=55 rd=7", alu_result_m, rd_m);
    end
    stall_m_i = 1'b1; imm_e = 32'h99; rd_e = 5'd9;
    for (int i = 0; i < 3; i++) begin
      flush_e_i = (i == 1);
      tick();
      checks++;
      if (alu_result_m !== 32'h55 || rd_m !== 5'd7 || reg_write_m !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d] got=%h rd=%0d rw=%b exp=55 rd=7 rw=1", i, alu_result_m, rd_m, reg_write_m);
      end
    end
    stall_m_i = 1'b0; flush_e_i = 1'b1;
    tick();
    checks++;
    if (alu_result_m !== 32'd0 || rd_m !== 5'd0 || reg_write_m !== 1'b0) begin
      failures++;
      $display("FAIL flush_bubble got=%h rd=%0d rw=%b exp=0", alu_result_m, rd_m, reg_write_m);
    end
    flush_e_i = 1'b0;
    tick();
    checks++;
    if (alu_result_m !== 32'h99 || rd_m !== 5'd9) begin
      failures++;
      $display("FAIL after_flush got=%h rd=%0d exp=99 rd=9", alu_result_m, rd_m);
    end
    nop();
    tick();
  endtask

  task automatic drive_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    nop();
    alu_control_e = 4'd11; rd1_e = a; rd2_e = b; reg_write_e = 1'b1; rd_e = rd;
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
    int busy_n, bub;
    logic [31:0] p;
    logic [4:0] rd;
    rd = 5'($urandom_range(1, 31));
    p = a * b;
    drive_mul(a, b, rd);
    #1;
    busy_n = 0;
    bub = 0;
    while (busy_e === 1'b1 && busy_n < 100) begin
      busy_n++;
      tick();
      if (reg_write_m !== 1'b0 || alu_result_m !== 32'd0) bub++;
    end
    checks++;
    if (busy_n != XLEN + 1) begin
      failures++;
      $display("FAIL mul_busy_len got=%0d exp=%0d", busy_n, XLEN + 1);
    end
    checks++;
    if (bub != 0) begin
      failures++;
      $display("FAIL mul_bubbles got=%0d non-bubble entries exp=0", bub);
    end
    tick();
    checks++;
    if (alu_result_m !== p || reg_write_m !== 1'b1 || rd_m !== rd) begin
      failures++;
      $display("FAIL mul_result a=%h b=%h got=%h rw=%b rd=%0d exp=%h rw=1 rd=%0d", a, b, alu_result_m, reg_write_m, rd_m, p, rd);
    end
  endtask

  task automatic check_no_write(input string tag);
    nop();
    tick();
    checks++;
    if (reg_write_m !== 1'b0) begin
      failures++;
      $display("FAIL %s extra write got=%b exp=0", tag, reg_write_m);
    end
  endtask

  task automatic test_mul();
    run_mul(32'hFFFF_FFFF, 32'd3);
    check_no_write("mul_single_pulse");
    for (int i = 0; i < 3; i++) begin
      run_mul($urandom, $urandom);
      check_no_write("mul_rand_pulse");
    end
  endtask

  task automatic test_back_to_back();
    run_mul($urandom, $urandom);
    run_mul($urandom, $urandom);
    check_no_write("b2b_pulse");
  endtask

  task automatic test_mul_abort();
    int writes;
    drive_mul(32'd12345, 32'd678, 5'd4);
    tick();
    repeat (9) tick();
    flush_e_i = 1'b1;
    tick();
    nop();
    #1;
    checks++;
    if (busy_e !== 1'b0) begin
      failures++;
      $display("FAIL flush_abort busy got=%b exp=0", busy_e);
    end
    writes = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (reg_write_m !== 1'b0) writes++;
    end
    checks++;
    if (writes != 0) begin
      failures++;
      $display("FAIL flush_abort writes got=%0d exp=0", writes);
    end
    drive_mul(32'd99, 32'd77, 5'd5);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nop();
    #1;
    checks++;
    if (busy_e !== 1'b0 || reg_write_m !== 1'b0 || alu_result_m !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid_run busy=%b rw=%b alu=%h exp=0", busy_e, reg_write_m, alu_result_m);
    end
    run_mul(32'd7, 32'd6);
    check_no_write("post_rst_pulse");
  endtask

  initial begin
    rst = 1'b1;
    nop();
    test_reset();
    test_directed();
    test_random();
    test_stall_flush();
    test_mul();
    test_back_to_back();
    test_mul_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
